// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 8-bit combinational ALU: buffers tagged requests
// in a FIFO, issues them one at a time, and returns captured results in order.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [7:0]                  cmd_a,
  input  logic [7:0]                  cmd_b,
  input  logic [TAG_W-1:0]            cmd_tag,
  output logic [2:0]                  alu_operation,
  output logic [7:0]                  alu_operand_A,
  output logic [7:0]                  alu_operand_B,
  input  logic [15:0]                 alu_result,
  input  logic                        alu_carry_flag,
  input  logic                        alu_zero_flag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [15:0]                 rsp_result,
  output logic                        rsp_carry,
  output logic                        rsp_zero,
  output logic [2:0]                  rsp_op,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [$clog2(FIFO_DEPTH):0] cmd_count,
  output logic [15:0]                 rsp_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 3 + 8 + 8 + TAG_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  // Command FIFO storage; entries carry no reset, occupancy is tracked separately.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       state_q, state_d;

  logic [2:0]       issue_op_q, issue_op_d;
  logic [7:0]       issue_a_q, issue_a_d;
  logic [7:0]       issue_b_q, issue_b_d;
  logic [TAG_W-1:0] issue_tag_q, issue_tag_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [15:0]      rsp_count_q, rsp_count_d;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               rsp_fire;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [2:0]         head_op;
  logic [7:0]         head_a;
  logic [7:0]         head_b;
  logic [TAG_W-1:0]   head_tag;

  assign wr_entry   = {cmd_op, cmd_a, cmd_b, cmd_tag};
  assign head_entry = fifo_mem[rd_ptr_q];
  assign {head_op, head_a, head_b, head_tag} = head_entry;

  assign cmd_ready  = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;
  assign rsp_fire   = rsp_valid_q && rsp_ready;

  // A new command is only ever taken from the FIFO head, never straight from cmd_*.
  assign pop = !fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_fire));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    issue_op_d   = issue_op_q;
    issue_a_d    = issue_a_q;
    issue_b_d    = issue_b_q;
    issue_tag_d  = issue_tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_op_d     = rsp_op_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_count_d  = rsp_count_q;

    if (pop) begin
      issue_op_d  = head_op;
      issue_a_d   = head_a;
      issue_b_d   = head_b;
      issue_tag_d = head_tag;
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // The ALU keeps a stale carry on non-arithmetic ops, so it is masked here.
        rsp_result_d = alu_result;
        rsp_carry_d  = ((issue_op_q == OP_ADD) || (issue_op_q == OP_SUB)) ?
                       alu_carry_flag : 1'b0;
        rsp_zero_d   = alu_zero_flag;
        rsp_op_d     = issue_op_q;
        rsp_tag_d    = issue_tag_q;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          rsp_count_d = rsp_count_q + 16'd1;
          state_d     = pop ? S_EXEC : S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      issue_op_q   <= '0;
      issue_a_q    <= '0;
      issue_b_q    <= '0;
      issue_tag_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_op_q     <= '0;
      rsp_tag_q    <= '0;
      rsp_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      issue_op_q   <= issue_op_d;
      issue_a_q    <= issue_a_d;
      issue_b_q    <= issue_b_d;
      issue_tag_q  <= issue_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_op_q     <= rsp_op_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_count_q  <= rsp_count_d;
    end
  end

  assign alu_operation = issue_op_q;
  assign alu_operand_A = issue_a_q;
  assign alu_operand_B = issue_b_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_tag    = rsp_tag_q;
  assign cmd_count  = count_q;
  assign rsp_count  = rsp_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU attached and
// a scoreboard of expected responses filled as commands are accepted.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic [2:0]  alu_operation;
  logic [7:0]  alu_operand_A;
  logic [7:0]  alu_operand_B;
  logic [15:0] alu_result;
  logic        alu_carry_flag;
  logic        alu_zero_flag;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic [2:0]  rsp_op;
  logic [3:0]  rsp_tag;
  logic [2:0]  cmd_count;
  logic [15:0] rsp_count;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic [2:0]  op;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_operation(alu_operation), .alu_operand_A(alu_operand_A),
    .alu_operand_B(alu_operand_B), .alu_result(alu_result),
    .alu_carry_flag(alu_carry_flag), .alu_zero_flag(alu_zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
    .rsp_tag(rsp_tag), .cmd_count(cmd_count), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, zero, result}. Non-arithmetic ops report a stale carry of 1.
  function automatic logic [17:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [15:0] r;
    logic        c;
    c = 1'b1;
    case (op)
      3'd0: begin r = {8'h00, a} + {8'h00, b}; c = r[8]; end
      3'd1: begin r = {8'h00, a - b}; c = (a < b); end
      3'd2: r = {8'h00, a} * {8'h00, b};
      3'd3: r = {8'h00, a & b};
      3'd4: r = {8'h00, a | b};
      3'd5: r = {8'h00, ~(a & b)};
      3'd6: r = {8'h00, ~(a | b)};
      default: r = {8'h00, a ^ b};
    endcase
    return {c, (r == 16'h0000), r};
  endfunction

  assign {alu_carry_flag, alu_zero_flag, alu_result} =
      alu_model(alu_operation, alu_operand_A, alu_operand_B);

  function automatic exp_t make_exp(input logic [2:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic [3:0] tag);
    logic [17:0] m;
    exp_t e;
    m     = alu_model(op, a, b);
    e.res = m[15:0];
    e.z   = m[16];
    e.c   = (op == 3'd0 || op == 3'd1) ? m[17] : 1'b0;
    e.op  = op;
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t got_rsp();
    exp_t g;
    g.res = rsp_result;
    g.c   = rsp_carry;
    g.z   = rsp_zero;
    g.op  = rsp_op;
    g.tag = rsp_tag;
    return g;
  endfunction

  task automatic cycle_end();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic offer(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tag, output bit acc);
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    acc       = v && cmd_ready;
    if (acc) exp_q.push_back(make_exp(op, a, b, tag));
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    cycle_end();
    cycle_end();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [38:0] rsp_bundle;
    logic [34:0] misc_bundle;
    bit          idle_ok;
    #1 rst = 1'b1;
    cycle_end();
    cycle_end();
    rsp_bundle  = {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_op, rsp_tag, rsp_count[12:0]};
    misc_bundle = {cmd_count, rsp_count[15:13], alu_operation, alu_operand_A, alu_operand_B, 5'b0};
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    end
    tests++;
    if (rsp_bundle !== 39'h0) begin
      fails++; $display("FAIL reset_rsp got %h want 0", rsp_bundle);
    end
    tests++;
    if (misc_bundle !== 35'h0) begin
      fails++; $display("FAIL reset_alu_counts got %h want 0", misc_bundle);
    end
    rst = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle_end();
      if (rsp_valid !== 1'b0 || cmd_count !== 3'd0) idle_ok = 1'b0;
    end
    tests++;
    if (!idle_ok) begin
      fails++; $display("FAIL reset_idle got rsp_valid=%b cmd_count=%0d want 0/0", rsp_valid, cmd_count);
    end
    $display("[TB] reset: checked reset values and idle after release");
  endtask

  task automatic test_single_add();
    bit   acc;
    int   k;
    exp_t e, g;
    do_reset();
    rsp_ready = 1'b1;
    offer(1'b1, 3'd0, 8'hFF, 8'h01, 4'd3, acc);
    tests++;
    if (!acc) begin
      fails++; $display("FAIL add_accept got cmd_ready=%b want 1", cmd_ready);
    end
    cycle_end();
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin
      cycle_end();
      k++;
    end
    tests++;
    if (k !== 2) begin
      fails++; $display("FAIL add_latency got %0d edges want 2", k);
    end
    tests++;
    if (rsp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_rsp();
      if (g !== e) begin
        fails++; $display("FAIL add_rsp got %h want %h", g, e);
      end
    end else begin
      fails++; $display("FAIL add_rsp got no response want %h", make_exp(3'd0, 8'hFF, 8'h01, 4'd3));
    end
    cycle_end();
    tests++;
    if (rsp_count !== 16'd1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL add_count got rsp_count=%0d rsp_valid=%b want 1/0", rsp_count, rsp_valid);
    end
    $display("[TB] single_add: ADD FF+01 tag 3, latency %0d", k);
  endtask

  task automatic test_flag_mask();
    logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd3};
    logic [7:0] as  [6] = '{8'hFF, 8'h05, 8'hF0, 8'hFF, 8'hFF, 8'hF0};
    logic [7:0] bs  [6] = '{8'h01, 8'h05, 8'h0F, 8'hFF, 8'h01, 8'h0F};
    int   idx, rcv;
    bit   acc;
    exp_t e, g;
    do_reset();
    rsp_ready = 1'b1;
    idx = 0;
    rcv = 0;
    for (int c = 0; c < 60 && !(idx == 6 && rcv == 6); c++) begin
      if (idx < 6) begin
        offer(1'b1, ops[idx], as[idx], bs[idx], 4'(idx + 1), acc);
        if (acc) idx++;
      end else begin
        offer(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, acc);
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL flag_extra got tag=%0d want none", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          g = got_rsp();
          if (g !== e) begin
            fails++; $display("FAIL flag_rsp got %h want %h", g, e);
          end
        end
        rcv++;
      end
      cycle_end();
    end
    cmd_valid = 1'b0;
    tests++;
    if (rcv !== 6 || rsp_count !== 16'd6) begin
      fails++; $display("FAIL flag_count got rcv=%0d rsp_count=%0d want 6/6", rcv, rsp_count);
    end
    $display("[TB] flag_mask: %0d responses with carry masking", rcv);
  endtask

  task automatic test_backpressure();
    int   idx, rcv, last_hs, first_hs;
    bit   acc, snap_ok, gap_ok, have_snap, ready_checked;
    exp_t snap, e, g;
    do_reset();
    rsp_ready = 1'b0;
    idx = 0;
    have_snap = 1'b0;
    snap_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      offer(1'b1, 3'(idx), 8'(idx * 17), 8'(idx + 3), 4'(idx + 8), acc);
      if (acc) idx++;
      if (rsp_valid) begin
        if (!have_snap) begin snap = got_rsp(); have_snap = 1'b1; end
        else if (got_rsp() !== snap) snap_ok = 1'b0;
      end
      cycle_end();
    end
    tests++;
    if (idx !== 5 || cmd_ready !== 1'b0 || cmd_count !== 3'd4) begin
      fails++; $display("FAIL bp_full got accepted=%0d cmd_ready=%b cmd_count=%0d want 5/0/4", idx, cmd_ready, cmd_count);
    end
    tests++;
    if (!snap_ok || !have_snap) begin
      fails++; $display("FAIL bp_stable got stable=%b seen=%b want 1/1", snap_ok, have_snap);
    end
    rsp_ready = 1'b1;
    rcv = 0;
    gap_ok = 1'b1;
    last_hs = 0;
    first_hs = 0;
    ready_checked = 1'b0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      if (rcv == 1 && !ready_checked) begin
        ready_checked = 1'b1;
        tests++;
        if (cmd_ready !== 1'b1 || cyc !== first_hs + 1) begin
          fails++; $display("FAIL bp_ready_reassert got cmd_ready=%b want 1", cmd_ready);
        end
      end
      if (idx < 6) begin
        offer(1'b1, 3'(idx), 8'(idx * 17), 8'(idx + 3), 4'(idx + 8), acc);
        if (acc) idx++;
      end else begin
        offer(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, acc);
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL bp_extra got tag=%0d want none", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          g = got_rsp();
          if (g !== e) begin
            fails++; $display("FAIL bp_rsp got %h want %h", g, e);
          end
        end
        if (rcv == 0) first_hs = cyc;
        else if (cyc - last_hs != 2) gap_ok = 1'b0;
        last_hs = cyc;
        rcv++;
      end
      cycle_end();
    end
    cmd_valid = 1'b0;
    tests++;
    if (rcv !== 6 || !gap_ok) begin
      fails++; $display("FAIL bp_drain got rcv=%0d gap_ok=%b want 6/1", rcv, gap_ok);
    end
    $display("[TB] backpressure: 5 buffered during stall, %0d drained", rcv);
  endtask

  task automatic test_stream();
    int   idx, rcv;
    bit   acc, cnt_ok;
    exp_t e, g;
    do_reset();
    idx = 0;
    rcv = 0;
    cnt_ok = 1'b1;
    for (int c = 0; c < 400 && rcv < 20; c++) begin
      rsp_ready = ($urandom_range(0, 1) == 1);
      if (idx < 20 && $urandom_range(0, 3) != 0) begin
        offer(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 4'(idx), acc);
        if (acc) idx++;
      end else begin
        offer(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, acc);
      end
      if (cmd_count > 3'd4) cnt_ok = 1'b0;
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL stream_extra got tag=%0d want none", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          g = got_rsp();
          if (g !== e) begin
            fails++; $display("FAIL stream_rsp got %h want %h", g, e);
          end
        end
        rcv++;
      end
      cycle_end();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tests++;
    if (rcv !== 20 || rsp_count !== 16'd20 || !cnt_ok) begin
      fails++; $display("FAIL stream_total got rcv=%0d rsp_count=%0d cnt_ok=%b want 20/20/1", rcv, rsp_count, cnt_ok);
    end
    $display("[TB] stream: %0d responses across pointer wrap", rcv);
  endtask

  task automatic test_reset_mid();
    int idx;
    bit acc, quiet_ok;
    do_reset();
    rsp_ready = 1'b1;
    offer(1'b1, 3'd4, 8'h12, 8'h34, 4'd1, acc);
    cycle_end();
    cmd_valid = 1'b0;
    for (int c = 0; c < 10 && rsp_count == 16'd0; c++) cycle_end();
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 15 && !(idx == 3 && rsp_valid && cmd_count == 3'd2); c++) begin
      if (idx < 3) begin
        offer(1'b1, 3'd7, 8'(idx), 8'hA5, 4'(idx + 4), acc);
        if (acc) idx++;
      end else begin
        offer(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, acc);
      end
      cycle_end();
    end
    cmd_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || cmd_count !== 3'd2 || rsp_count !== 16'd1) begin
      fails++; $display("FAIL rmid_setup got rsp_valid=%b cmd_count=%0d rsp_count=%0d want 1/2/1", rsp_valid, cmd_count, rsp_count);
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || cmd_count !== 3'd0 || rsp_count !== 16'd0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_async got rsp_valid=%b cmd_count=%0d rsp_count=%0d cmd_ready=%b want 0/0/0/1", rsp_valid, cmd_count, rsp_count, cmd_ready);
    end
    cycle_end();
    rst = 1'b0;
    rsp_ready = 1'b1;
    exp_q.delete();
    quiet_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid !== 1'b0 || cmd_count !== 3'd0 || rsp_count !== 16'd0) quiet_ok = 1'b0;
      cycle_end();
    end
    tests++;
    if (!quiet_ok) begin
      fails++; $display("FAIL rmid_quiet got rsp_valid=%b rsp_count=%0d want 0/0", rsp_valid, rsp_count);
    end
    $display("[TB] reset_mid: queued work discarded");
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_flag_mask();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side driver for the 8-bit ALU. Accepts tagged operation requests over a valid/ready stream and buffers them in a small FIFO. It issues one request at a time onto the ALU's combinational operation/operand ports, captures the 16-bit result and flags, and returns them in order on a valid/ready response stream. It sits between the instruction/control logic and the ALU, and owns all sequencing, back-pressure and flag sanitising.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- TAG_W, 4, width of the opaque request tag
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  FIFO can accept
- cmd_op  in  3  ADD=000 SUB=001 MUL=010 AND=011 OR=100 NAND=101 NOR=110 XOR=111
- cmd_a, cmd_b  in  8 each  operands
- cmd_tag  in  TAG_W  returned unchanged with response
- alu_operation  out  3  to ALU operation
- alu_operand_A, alu_operand_B  out  8 each  to ALU operands
- alu_result  in  16  from ALU
- alu_carry_flag, alu_zero_flag  in  1 each  from ALU
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  16  captured result
- rsp_carry, rsp_zero  out  1 each  sanitised flags
- rsp_op  out  3  op of this response
- rsp_tag  out  TAG_W  tag of this response
- cmd_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- rsp_count  out  16  completed responses, wraps at 0xFFFF→0x0000

## Operation
- Command FIFO: push on cmd_valid&&cmd_ready. cmd_ready = (cmd_count != FIFO_DEPTH). No bypass: a command always enters the FIFO first. Push and pop on the same edge is legal; occupancy is unchanged.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: FIFO non-empty → pop head into issue registers (op, a, b, tag), go EXEC. Otherwise stay.
  - EXEC: capture alu_result, flags, op and tag into response registers; set rsp_valid; go RESP.
  - RESP: hold all rsp_* stable while !rsp_ready. On rsp_valid&&rsp_ready: clear rsp_valid, increment rsp_count, then pop the next command and go EXEC if the FIFO is non-empty, else go IDLE.
- alu_* outputs are driven directly from the issue registers. They are stable from pop through capture and hold the last values in RESP and IDLE.
- Flag sanitising: rsp_carry = alu_carry_flag only when the op is ADD or SUB, else 0. This masks the ALU's held carry on other ops. rsp_zero passes through unchanged.
- Responses are strictly in command order. No command is dropped or duplicated.

## Timing
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, cmd_count=0, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_op=0, rsp_tag=0, alu_*=0, rsp_count=0.
- Reset mid-operation: in-flight and queued commands are discarded; no response is produced for them after release.
- Latency from an idle, empty block: command accepted at edge N → popped at N+1 → rsp_valid high after N+2.
- Throughput: at most one response every 2 cycles. After a handshake at edge M, the next rsp_valid rises after M+1.
- Full FIFO: cmd_ready=0 on the cycle cmd_count==FIFO_DEPTH. The command held in the issue/response registers does not count toward occupancy, so total buffering is FIFO_DEPTH+1.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Occupancy stays correct across wrap.
- rsp_count wraps silently.

## Test plan
- Reset with rst=1 → all outputs at their listed reset values, cmd_ready=1. Release rst with no commands → FSM stays IDLE, rsp_valid=0.
- ADD a=0xFF b=0x01 tag=3, rsp_ready=1 → rsp_valid 2 edges after accept; result=0x0100, carry=1, zero=0, tag=3, op=000; rsp_count=1.
- SUB 0x05−0x05, then AND 0xF0&0x0F, then MUL 0xFF*0xFF → responses in order: (0x0000, c=0, z=1), (0x0000, c=0, z=1), (0xFE01, c=0, z=0). Carry stays 0 on AND/MUL even when issued directly after an ADD that set the ALU carry.
- rsp_ready=0 with cmd_valid held, 6 distinct tags (depth 4) → 5 commands accepted, then cmd_ready=0 and cmd_count=4; rsp_* stable throughout the stall. Raise rsp_ready → tags return in push order, one per 2 cycles, cmd_ready reasserts after the first pop.
- Stream 20 commands with random rsp_ready → no loss or reorder across pointer wrap, cmd_count never exceeds 4, rsp_count=20.
- Assert rst while in RESP with 2 commands queued → rsp_valid falls immediately, cmd_count=0, rsp_count=0; no responses after release.
